// File: rtl/adder64_serial_seq.sv
// rtl/adder64_serial_seq.sv - WIDTH-bit adder built by stepping a SLICE-bit lookahead slice LSB to MSB
// One slice per clock; carry is registered between steps, valid/ready on both sides.
module adder64_serial_seq #(
   parameter int WIDTH = 64,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int SL     = (SLICE < 1) ? 1 : SLICE;
   localparam int N      = WIDTH / SL;
   localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

   generate
      if (SLICE < 1 || (WIDTH % SL) != 0) begin : g_bad_params
         $error("adder64_serial_seq: WIDTH must be a positive multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [SL-1:0]      sa, sb, sg, sp, ss;
   logic [SL:0]        sc;
   logic               acc_c, acc_p;
   logic               accept, release_res;

   // Slice adder: each carry is the flattened generate/propagate product back to carry_q.
   always_comb begin
      sa    = a_q[step_q*SL +: SL];
      sb    = b_q[step_q*SL +: SL];
      sg    = sa & sb;
      sp    = sa ^ sb;
      sc    = '0;
      sc[0] = carry_q;
      acc_c = 1'b0;
      acc_p = 1'b0;
      for (int i = 0; i < SL; i++) begin
         acc_c = sg[i];
         acc_p = sp[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc_c = acc_c | (acc_p & sg[j]);
            acc_p = acc_p & sp[j];
         end
         sc[i+1] = acc_c | (acc_p & carry_q);
      end
      ss = sp ^ sc[SL-1:0];
   end

   assign accept      = in_valid && (state_q == S_IDLE);
   assign release_res = out_ready && (state_q == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               step_d  = '0;
               sum_d   = '0;
            end
         end
         S_RUN: begin
            sum_d[step_q*SL +: SL] = ss;
            carry_d                = sc[SL];
            if (step_q == LAST_STEP) begin
               cout_d  = sc[SL];
               ovf_d   = sc[SL-1] ^ sc[SL];
               state_d = S_DONE;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         S_DONE: begin
            if (release_res) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      sum       = sum_q;
      cout      = cout_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_adder64_serial_seq.sv
// tb/tb_adder64_serial_seq.sv - directed and random checks of adder64_serial_seq against an arithmetic model
module tb_adder64_serial_seq;

   localparam int W = 64;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   adder64_serial_seq #(.WIDTH(W), .SLICE(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] r;
      r = ref_add(x, y, c);
      return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
   endtask

   // Accept one operand pair, then wait for out_valid and check latency.
   task automatic launch_and_wait(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int cnt;
      wait_ready(tag);
      a = x; b = y; cin = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = $urandom(); b = $urandom(); cin = $urandom();
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         tick();
         cnt++;
      end
      check({tag, "_latency"}, cnt, N);
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W:0] r;
      r = ref_add(x, y, c);
      check({tag, "_sum"},  {1'b0, sum}, {1'b0, r[W-1:0]});
      check({tag, "_cout"}, cout, r[W]);
      check({tag, "_ovf"},  ovf, ref_ovf(x, y, c));
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      launch_and_wait(tag, x, y, c);
      check_result(tag, x, y, c);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_after"}, in_ready, 1);
   endtask

   logic [W-1:0] pa [2];
   logic [W-1:0] pb [2];
   logic         pc [2];
   int           acc_cyc [2];
   logic [W-1:0] s_sum;
   logic         s_cout, s_ovf;

   initial begin
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", {1'b0, sum}, 0);
      check("rst_flags", {cout, ovf}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      do_op("t1", 64'd1, 64'd2, 1'b0);
      do_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      do_op("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

      // Hold the result in DONE with out_ready low.
      launch_and_wait("t4", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1);
      check("t4_busy", busy, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_in_ready", in_ready, 0);
         check_result("t4_hold", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_release_in_ready", in_ready, 1);
      check("t4_release_valid", out_valid, 0);

      // Asynchronous reset in the middle of RUN.
      wait_ready("t5");
      a = 64'h1234; b = 64'h4321; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("t5_running", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_in_ready", in_ready, 1);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_sum", {1'b0, sum}, 0);
      check("t5_rst_flags", {cout, ovf}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_op("t5b", 64'd5, 64'd6, 1'b0);

      // Back-to-back offers with out_ready high: one accept per N+2 cycles.
      for (int i = 0; i < 2; i++) begin
         pa[i] = {$urandom(), $urandom()};
         pb[i] = {$urandom(), $urandom()};
         pc[i] = 1'($urandom());
      end
      begin
         int cyc, n_acc, n_res;
         logic r_in, r_out;
         cyc = 0; n_acc = 0; n_res = 0;
         out_ready = 1'b1;
         a = pa[0]; b = pb[0]; cin = pc[0]; in_valid = 1'b1;
         while (n_res < 2 && cyc < 300) begin
            r_in   = in_ready;
            r_out  = out_valid;
            s_sum  = sum;
            s_cout = cout;
            s_ovf  = ovf;
            tick();
            cyc++;
            if (r_in) begin
               if (n_acc < 2) acc_cyc[n_acc] = cyc;
               n_acc++;
               if (n_acc < 2) begin
                  a = pa[n_acc]; b = pb[n_acc]; cin = pc[n_acc];
               end else begin
                  in_valid = 1'b0;
               end
            end
            if (r_out) begin
               if (n_res < 2) begin
                  logic [W:0] r;
                  r = ref_add(pa[n_res], pb[n_res], pc[n_res]);
                  check("t6_sum", {1'b0, s_sum}, {1'b0, r[W-1:0]});
                  check("t6_cout", s_cout, r[W]);
                  check("t6_ovf", s_ovf, ref_ovf(pa[n_res], pb[n_res], pc[n_res]));
               end
               n_res++;
            end
         end
         in_valid = 1'b0;
         out_ready = 1'b0;
         check("t6_results", n_res, 2);
         check("t6_accepts", n_acc, 2);
         check("t6_interval", acc_cyc[1] - acc_cyc[0], N + 2);
      end

      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] x, y;
         logic c;
         x = {$urandom(), $urandom()};
         y = {$urandom(), $urandom()};
         c = 1'($urandom());
         if (i == 0) y = ~x;
         do_op("rand", x, y, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
